// File: rtl/rr_arbiter_iob.sv
// rr_arbiter_iob -- registered N-way arbiter for interconnect request sources.
//
// Picks one requester per decision and drives the crossbar mux select. Two
// priority encoders run side by side: one on the raw requests, one on the
// requests filtered by the round-robin mask. The masked result wins when it
// finds anything, which gives the rotating fairness in round-robin mode.
//
// Parameters
//   PORTS          number of requesters (>=1)
//   ARB_RR         1: round-robin, 0: fixed priority
//   ARB_BLOCK      1: hold a grant once issued, 0: re-arbitrate every cycle
//   ARB_BLOCK_ACK  with ARB_BLOCK=1: 1 hold until acknowledge, 0 hold while request stays high
//   LSB_PRIORITY   "HIGH": lowest index wins, "LOW": highest index wins
//
// Ports
//   clk            clock, all state on the rising edge
//   rst            synchronous active-high reset
//   request        per-port request level
//   acknowledge    per-port transfer-done pulse (used when ARB_BLOCK_ACK=1)
//   grant          registered one-hot grant, zero when idle
//   grant_valid    registered, high while any grant is active
//   grant_encoded  registered index of the granted port, zero when idle

`timescale 1ns/1ps

// priority_encoder_iob -- combinational priority encoder.
//   input_unencoded   request vector
//   output_valid      any bit set
//   output_encoded    index of the winning bit (zero when none)
//   output_unencoded  one-hot of the winning bit (zero when none)
module priority_encoder_iob #(
   parameter int WIDTH        = 4,
   parameter     LSB_PRIORITY = "HIGH",
   parameter int IW           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] input_unencoded,
   output logic             output_valid,
   output logic [IW-1:0]    output_encoded,
   output logic [WIDTH-1:0] output_unencoded
);

   // The scan runs from the losing end towards the winning end so the last
   // set bit seen is the winner.
   always_comb begin
      output_valid     = |input_unencoded;
      output_encoded   = '0;
      output_unencoded = '0;
      if (LSB_PRIORITY == "HIGH") begin
         for (int unsigned i = WIDTH; i > 0; i--) begin
            if (input_unencoded[i-1]) begin
               output_encoded     = IW'(i - 1);
               output_unencoded   = '0;
               output_unencoded[i-1] = 1'b1;
            end
         end
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (input_unencoded[i]) begin
               output_encoded      = IW'(i);
               output_unencoded    = '0;
               output_unencoded[i] = 1'b1;
            end
         end
      end
   end

endmodule

module rr_arbiter_iob #(
   parameter int PORTS         = 4,
   parameter int ARB_RR        = 1,
   parameter int ARB_BLOCK     = 1,
   parameter int ARB_BLOCK_ACK = 1,
   parameter     LSB_PRIORITY  = "HIGH",
   parameter int IW            = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] request,
   input  logic [PORTS-1:0] acknowledge,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [IW-1:0]    grant_encoded
);

   logic [PORTS-1:0] grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic [IW-1:0]    grant_enc_q, grant_enc_d;
   logic [PORTS-1:0] mask_q, mask_d;

   logic [PORTS-1:0] req_masked;
   logic             u_valid, m_valid;
   logic [IW-1:0]    u_idx, m_idx, win_idx;
   logic [PORTS-1:0] u_oh, m_oh, win_oh;
   logic [PORTS-1:0] mask_win;
   int unsigned      win_pos;

   assign req_masked = request & mask_q;

   priority_encoder_iob #(
      .WIDTH        (PORTS),
      .LSB_PRIORITY (LSB_PRIORITY),
      .IW           (IW)
   ) u_enc_unmasked (
      .input_unencoded  (request),
      .output_valid     (u_valid),
      .output_encoded   (u_idx),
      .output_unencoded (u_oh)
   );

   priority_encoder_iob #(
      .WIDTH        (PORTS),
      .LSB_PRIORITY (LSB_PRIORITY),
      .IW           (IW)
   ) u_enc_masked (
      .input_unencoded  (req_masked),
      .output_valid     (m_valid),
      .output_encoded   (m_idx),
      .output_unencoded (m_oh)
   );

   always_comb begin
      if ((ARB_RR != 0) && m_valid) begin
         win_idx = m_idx;
         win_oh  = m_oh;
      end else begin
         win_idx = u_idx;
         win_oh  = u_oh;
      end

      // Mask keeps only the ports on the lower-priority side of the winner;
      // it empties after the edge port so the next search wraps around.
      win_pos  = 32'(win_idx);
      mask_win = '0;
      for (int unsigned j = 0; j < PORTS; j++) begin
         if (LSB_PRIORITY == "HIGH") begin
            mask_win[j] = (j > win_pos);
         end else begin
            mask_win[j] = (j < win_pos);
         end
      end

      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      grant_enc_d   = grant_enc_q;
      mask_d        = mask_q;

      if ((ARB_BLOCK != 0) && (ARB_BLOCK_ACK == 0) && (|(grant_q & request))) begin
         // holder still requesting: keep everything
      end else if ((ARB_BLOCK != 0) && (ARB_BLOCK_ACK != 0) && grant_valid_q &&
                   !(|(grant_q & acknowledge))) begin
         // waiting for the holder's acknowledge: keep everything
      end else if (u_valid) begin
         grant_d       = win_oh;
         grant_valid_d = 1'b1;
         grant_enc_d   = win_idx;
         if (ARB_RR != 0) begin
            mask_d = mask_win;
         end
      end else begin
         grant_d       = '0;
         grant_valid_d = 1'b0;
         grant_enc_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_enc_q   <= '0;
         mask_q        <= '0;
      end else begin
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_enc_q   <= grant_enc_d;
         mask_q        <= mask_d;
      end
   end

   assign grant         = grant_q;
   assign grant_valid   = grant_valid_q;
   assign grant_encoded = grant_enc_q;

endmodule

// File: tb/tb_rr_arbiter_iob.sv
// tb_rr_arbiter_iob -- directed self-checking bench for rr_arbiter_iob.
// Main instance uses the default round-robin / hold-until-ack setup; extra
// instances cover fixed priority in both directions and hold-while-request.

`timescale 1ns/1ps

module tb_rr_arbiter_iob;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] request, acknowledge;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_encoded;

   logic [3:0] req_fp;
   logic [3:0] ack_zero;
   logic [3:0] g_fh, g_fl;
   logic       gv_fh, gv_fl;
   logic [1:0] ge_fh, ge_fl;

   logic [3:0] req_hr;
   logic [3:0] g_hr;
   logic       gv_hr;
   logic [1:0] ge_hr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rr_arbiter_iob #(
      .PORTS(4), .ARB_RR(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_PRIORITY("HIGH")
   ) dut (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded)
   );

   rr_arbiter_iob #(
      .PORTS(4), .ARB_RR(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_PRIORITY("HIGH")
   ) dut_fh (
      .clk(clk), .rst(rst), .request(req_fp), .acknowledge(ack_zero),
      .grant(g_fh), .grant_valid(gv_fh), .grant_encoded(ge_fh)
   );

   rr_arbiter_iob #(
      .PORTS(4), .ARB_RR(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_PRIORITY("LOW")
   ) dut_fl (
      .clk(clk), .rst(rst), .request(req_fp), .acknowledge(ack_zero),
      .grant(g_fl), .grant_valid(gv_fl), .grant_encoded(ge_fl)
   );

   rr_arbiter_iob #(
      .PORTS(4), .ARB_RR(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_PRIORITY("HIGH")
   ) dut_hr (
      .clk(clk), .rst(rst), .request(req_hr), .acknowledge(ack_zero),
      .grant(g_hr), .grant_valid(gv_hr), .grant_encoded(ge_hr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks grant, grant_valid and grant_encoded of the main instance together.
   task automatic check_main(input string tag, input logic [3:0] g, input logic v, input logic [1:0] e);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".valid"}, 32'(grant_valid), 32'(v));
      check({tag, ".enc"},   32'(grant_encoded), 32'(e));
   endtask

   int exp_seq [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst         = 1'b1;
      request     = 4'b1111;
      acknowledge = 4'b0000;
      req_fp      = 4'b1111;
      req_hr      = 4'b1111;
      ack_zero    = 4'b0000;

      // T1: reset dominates pending requests
      for (int i = 0; i < 3; i++) begin
         tick();
         check_main("t1_reset", 4'b0000, 1'b0, 2'd0);
         check("t1_reset.fh", 32'(g_fh), 32'd0);
         check("t1_reset.hr", 32'(g_hr), 32'd0);
      end

      // T2: rotation 0,1,2,3,0 with an ack on the granted port each cycle
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_main("t2_rot", 4'(4'b0001 << exp_seq[i]), 1'b1, 2'(exp_seq[i]));
         acknowledge = 4'(4'b0001 << exp_seq[i]);
      end
      acknowledge = 4'b0000;

      // T3: holder drops request, grant held until its ack
      rst = 1'b1; tick(); rst = 1'b0;
      request = 4'b0101;
      tick();
      check_main("t3_first", 4'b0001, 1'b1, 2'd0);
      request = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_main("t3_hold", 4'b0001, 1'b1, 2'd0);
      end
      acknowledge = 4'b0001;
      tick();
      check_main("t3_after_ack", 4'b0100, 1'b1, 2'd2);
      acknowledge = 4'b0000;

      // T4: stray ack ignored, real ack regrants per mask
      rst = 1'b1; tick(); rst = 1'b0;
      request = 4'b0010;
      tick();
      check_main("t4_first", 4'b0010, 1'b1, 2'd1);
      request     = 4'b1111;
      acknowledge = 4'b0100;
      tick();
      check_main("t4_stray", 4'b0010, 1'b1, 2'd1);
      acknowledge = 4'b0010;
      tick();
      check_main("t4_regrant", 4'b0100, 1'b1, 2'd2);
      // only the holder still requests: it is granted again after ack
      request     = 4'b0100;
      acknowledge = 4'b0100;
      tick();
      check_main("t4_self", 4'b0100, 1'b1, 2'd2);
      // ack with no request goes idle
      request = 4'b0000;
      tick();
      check_main("t4_idle", 4'b0000, 1'b0, 2'd0);
      // mask survived idle: port 3 beats port 2
      acknowledge = 4'b0000;
      request     = 4'b1100;
      tick();
      check_main("t4_mask_kept", 4'b1000, 1'b1, 2'd3);
      // stray ack while idle is ignored after going idle again
      request     = 4'b0000;
      acknowledge = 4'b1000;
      tick();
      check_main("t4_idle2", 4'b0000, 1'b0, 2'd0);
      acknowledge = 4'b0100;
      tick();
      check_main("t4_idle_ack", 4'b0000, 1'b0, 2'd0);
      acknowledge = 4'b0000;

      // T5: fixed priority, re-arbitrated every cycle
      req_fp = 4'b1010;
      tick();
      check("t5_fh_1010", 32'(g_fh), 32'b0010);
      check("t5_fl_1010", 32'(g_fl), 32'b1000);
      check("t5_fl_enc",  32'(ge_fl), 32'd3);
      req_fp = 4'b0110;
      tick();
      check("t5_fh_0110", 32'(g_fh), 32'b0010);
      check("t5_fl_0110", 32'(g_fl), 32'b0100);
      check("t5_fh_enc",  32'(ge_fh), 32'd1);
      req_fp = 4'b0000;
      tick();
      check("t5_fh_idle", 32'(gv_fh), 32'd0);
      check("t5_fl_idle", 32'(g_fl), 32'd0);

      // HOLD_REQ variant: hold while request stays, rotate when it drops
      rst = 1'b1; tick(); rst = 1'b0;
      req_hr = 4'b0101;
      tick();
      check("hr_first", 32'(g_hr), 32'b0001);
      req_hr = 4'b0111;
      tick();
      check("hr_hold", 32'(g_hr), 32'b0001);
      req_hr = 4'b0110;
      tick();
      check("hr_drop", 32'(g_hr), 32'b0010);
      check("hr_enc",  32'(ge_hr), 32'd1);
      req_hr = 4'b0100;
      tick();
      check("hr_next", 32'(g_hr), 32'b0100);
      check("hr_valid", 32'(gv_hr), 32'd1);

      // T6: reset mid-hold clears grant and mask
      request = 4'b1111;
      tick();
      check_main("t6_g0", 4'b0001, 1'b1, 2'd0);
      acknowledge = 4'b0001;
      tick();
      check_main("t6_g1", 4'b0010, 1'b1, 2'd1);
      acknowledge = 4'b0010;
      tick();
      check_main("t6_g2", 4'b0100, 1'b1, 2'd2);
      acknowledge = 4'b0000;
      tick();
      check_main("t6_hold", 4'b0100, 1'b1, 2'd2);
      rst = 1'b1;
      tick();
      check_main("t6_rst", 4'b0000, 1'b0, 2'd0);
      rst = 1'b0;
      tick();
      check_main("t6_after", 4'b0001, 1'b1, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
